// File: rtl/clkdiv_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clkdiv_ctrl_pkg : state encoding and constants for clkdiv_ctrl       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package clkdiv_ctrl_pkg;

  localparam logic [1:0] C_ST_OFF   = 2'd0;
  localparam logic [1:0] C_ST_GATE  = 2'd1;
  localparam logic [1:0] C_ST_RUN   = 2'd2;
  localparam logic [1:0] C_ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    ST_OFF   = C_ST_OFF,
    ST_GATE  = C_ST_GATE,
    ST_RUN   = C_ST_RUN,
    ST_DRAIN = C_ST_DRAIN
  } state_t;

  // Ratios strictly below this value put the divider in bypass.
  localparam int unsigned C_BYPASS_LIMIT = 2;

endpackage
`default_nettype wire

// File: rtl/clkdiv_ctrl_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clkdiv_ctrl_timer : loadable down-counter, holds at zero, done flag  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module clkdiv_ctrl_timer #(
  parameter int WIDTH = 10
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/clkdiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clkdiv_ctrl : glitch-safe enable/ratio sequencer for a clock divider |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module clkdiv_ctrl
  import clkdiv_ctrl_pkg::*;
#(
  parameter int RATIO_WIDTH   = 8,
  parameter int DEFAULT_RATIO = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic                   i_cfg_valid,
  input  logic [RATIO_WIDTH-1:0] i_cfg_ratio,
  output logic                   o_cfg_ready,
  input  logic                   i_div_clk,
  output logic                   o_clk_en,
  output logic [RATIO_WIDTH-1:0] o_div_ratio,
  output logic                   o_locked,
  output logic                   o_busy
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TIMER_W  = (RATIO_WIDTH + 2 > SETTLE_W) ? RATIO_WIDTH + 2 : SETTLE_W;

  localparam logic [TIMER_W-1:0]     C_SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0]     C_DRAIN_LOAD  = TIMER_W'((1 << (RATIO_WIDTH + 1)) - 1);
  localparam logic [RATIO_WIDTH-1:0] C_DEFAULT     = RATIO_WIDTH'(DEFAULT_RATIO);
  localparam logic [RATIO_WIDTH-1:0] C_BYPASS      = RATIO_WIDTH'(C_BYPASS_LIMIT);

  state_t                 r_state, w_state_nxt;
  logic                   r_clk_en, w_clk_en_nxt;
  logic [RATIO_WIDTH-1:0] r_div_ratio, w_div_ratio_nxt;
  logic [RATIO_WIDTH-1:0] r_pend, w_pend_nxt;
  logic                   r_pend_vld, w_pend_vld_nxt;
  logic                   r_locked, w_locked_nxt;
  logic                   r_div_clk_q;
  logic                   w_accept, w_div_rise, w_bypass;
  logic                   w_tmr_load, w_tmr_done;
  logic [TIMER_W-1:0]     w_tmr_val, w_lock_load;

  assign o_cfg_ready = (r_state == ST_OFF) || (r_state == ST_RUN);
  assign o_busy      = (r_state == ST_GATE) || (r_state == ST_DRAIN);
  assign o_clk_en    = r_clk_en;
  assign o_div_ratio = r_div_ratio;
  assign o_locked    = r_locked;

  assign w_accept    = i_cfg_valid && o_cfg_ready;
  assign w_div_rise  = i_div_clk && !r_div_clk_q;
  assign w_bypass    = (r_div_ratio < C_BYPASS);
  // Lock lands `ratio` cycles after the enable rise: load ratio-1 on RUN entry.
  assign w_lock_load = w_bypass ? '0 : (TIMER_W'(r_div_ratio) - TIMER_W'(1));

  clkdiv_ctrl_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .i_ref_clk  (i_ref_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_OFF;
      r_clk_en    <= 1'b0;
      r_div_ratio <= C_DEFAULT;
      r_pend      <= C_DEFAULT;
      r_pend_vld  <= 1'b0;
      r_locked    <= 1'b0;
      r_div_clk_q <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clk_en    <= w_clk_en_nxt;
      r_div_ratio <= w_div_ratio_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_locked    <= w_locked_nxt;
      r_div_clk_q <= i_div_clk;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_clk_en_nxt    = r_clk_en;
    w_div_ratio_nxt = r_div_ratio;
    w_pend_nxt      = r_pend;
    w_pend_vld_nxt  = r_pend_vld;
    w_locked_nxt    = r_locked;
    w_tmr_load      = 1'b0;
    w_tmr_val       = '0;

    case (r_state)
      ST_OFF: begin
        w_clk_en_nxt = 1'b0;
        w_locked_nxt = 1'b0;
        if (w_accept) begin
          w_div_ratio_nxt = i_cfg_ratio;
        end
        if (i_enable) begin
          w_state_nxt = ST_GATE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = C_SETTLE_LOAD;
        end
      end

      ST_GATE: begin
        if (!i_enable) begin
          w_state_nxt = ST_OFF;
        end else if (w_tmr_done) begin
          w_state_nxt  = ST_RUN;
          w_clk_en_nxt = 1'b1;
          w_locked_nxt = w_bypass;
          w_tmr_load   = 1'b1;
          w_tmr_val    = w_lock_load;
        end
      end

      ST_RUN: begin
        if (w_accept || !i_enable) begin
          w_state_nxt  = ST_DRAIN;
          w_locked_nxt = 1'b0;
          w_tmr_load   = 1'b1;
          w_tmr_val    = C_DRAIN_LOAD;
          if (w_accept) begin
            w_pend_nxt     = i_cfg_ratio;
            w_pend_vld_nxt = 1'b1;
          end
        end else if (w_tmr_done) begin
          w_locked_nxt = 1'b1;
        end
      end

      ST_DRAIN: begin
        w_locked_nxt = 1'b0;
        // Gate and reload only at a phase boundary (or bypass / timeout).
        if (w_bypass || w_div_rise || w_tmr_done) begin
          w_clk_en_nxt   = 1'b0;
          w_pend_vld_nxt = 1'b0;
          if (r_pend_vld) begin
            w_div_ratio_nxt = r_pend;
          end
          if (i_enable) begin
            w_state_nxt = ST_GATE;
            w_tmr_load  = 1'b1;
            w_tmr_val   = C_SETTLE_LOAD;
          end else begin
            w_state_nxt = ST_OFF;
          end
        end
      end

      default: begin
        w_state_nxt = ST_OFF;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_clkdiv_ctrl : self-checking bench for clkdiv_ctrl                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_clkdiv_ctrl;

  localparam int RW      = 8;
  localparam int DEF_R   = 8;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [RW-1:0] cfg_ratio = '0;
  logic          cfg_ready;
  logic          div_clk;
  logic          clk_en;
  logic [RW-1:0] div_ratio;
  logic          locked;
  logic          busy;
  logic          hold_low = 1'b0;
  int            dcnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Behavioural model: phase name plus age (cycles spent in the phase).
  int m_mode;    // 0 OFF, 1 GATE, 2 RUN, 3 DRAIN
  int m_age;
  int m_en;
  int m_ratio;
  int m_locked;
  int m_pend;    // -1 when no ratio is waiting
  int m_prev_div;

  clkdiv_ctrl #(
    .RATIO_WIDTH   (RW),
    .DEFAULT_RATIO (DEF_R),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .i_ref_clk   (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_cfg_valid (cfg_valid),
    .i_cfg_ratio (cfg_ratio),
    .o_cfg_ready (cfg_ready),
    .i_div_clk   (div_clk),
    .o_clk_en    (clk_en),
    .o_div_ratio (div_ratio),
    .o_locked    (locked),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int dnext(input int c, input int r);
    return (c + 1 >= r) ? 0 : c + 1;
  endfunction

  // Stand-in divider: low for the first ratio/2 counts of each period.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt    <= 0;
      div_clk <= 1'b0;
    end else if (!clk_en) begin
      dcnt    <= 0;
      div_clk <= 1'b0;
    end else begin
      dcnt    <= dnext(dcnt, int'(div_ratio));
      div_clk <= hold_low ? 1'b0 : (dnext(dcnt, int'(div_ratio)) >= int'(div_ratio) / 2);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_en = 0; m_ratio = DEF_R;
    m_locked = 0; m_pend = -1; m_prev_div = 0;
  endtask

  task automatic model_step();
    bit rise;
    bit acc;
    rise = (div_clk == 1'b1) && (m_prev_div == 0);
    m_prev_div = int'(div_clk);
    acc = cfg_valid && (m_mode == 0 || m_mode == 2);
    case (m_mode)
      0: begin
        if (acc) m_ratio = int'(cfg_ratio);
        if (enable) begin m_mode = 1; m_age = 0; end
      end
      1: begin
        if (!enable) m_mode = 0;
        else begin
          m_age++;
          if (m_age == SETTLE) begin
            m_mode = 2; m_age = 0; m_en = 1; m_locked = (m_ratio < 2);
          end
        end
      end
      2: begin
        if (acc || !enable) begin
          m_mode = 3; m_age = 0; m_locked = 0;
          if (acc) m_pend = int'(cfg_ratio);
        end else begin
          m_age++;
          if (m_age >= m_ratio) m_locked = 1;
        end
      end
      default: begin
        m_age++;
        if (m_ratio < 2 || rise || m_age == TIMEOUT) begin
          m_en = 0;
          if (m_pend >= 0) m_ratio = m_pend;
          m_pend = -1;
          m_mode = enable ? 1 : 0;
          m_age = 0;
        end
      end
    endcase
  endtask

  // Compare process: model advances on each edge, outputs checked 1 ns later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (clk) cyc++;
      if (!rst_n) model_reset();
      else model_step();
      #1;
      chk("clk_en", int'(clk_en), m_en);
      chk("div_ratio", int'(div_ratio), m_ratio);
      chk("locked", int'(locked), m_locked);
      chk("busy", int'(busy), int'(m_mode == 1 || m_mode == 3));
      chk("cfg_ready", int'(cfg_ready), int'(m_mode == 0 || m_mode == 2));
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0: return clk_en;
      1: return locked;
      default: return busy;
    endcase
  endfunction

  // Waits (on negedges) until the selected output equals val; returns cyc.
  task automatic wait_sig(input int sel, input logic val, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sig(sel) == val) begin
        at = cyc;
        return;
      end
    end
    chk($sformatf("wait_timeout_sel%0d", sel), 0, 1);
  endtask

  initial begin
    int n0;
    int at;
    int t;

    repeat (3) @(negedge clk);
    chk("rst_clk_en", int'(clk_en), 0);
    chk("rst_ratio", int'(div_ratio), 8);
    chk("rst_locked", int'(locked), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    rst_n = 1'b1;

    // OFF -> RUN at default ratio
    @(negedge clk);
    enable = 1'b1;
    n0 = cyc;
    wait_sig(0, 1'b1, 20, at);
    chk("off_to_run_lat", at - n0, 5);
    chk("run_ratio", int'(div_ratio), 8);
    t = at;
    wait_sig(1, 1'b1, 20, at);
    chk("lock_lat_8", at - t, 8);

    // Ratio change 8 -> 5
    @(negedge clk);
    cfg_valid = 1'b1; cfg_ratio = 8'd5;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("acc_busy", int'(busy), 1);
    chk("acc_ready", int'(cfg_ready), 0);
    chk("acc_locked", int'(locked), 0);
    wait_sig(0, 1'b0, 40, at);
    chk("drop_ratio", int'(div_ratio), 5);
    t = at;
    wait_sig(0, 1'b1, 20, at);
    chk("settle_low", at - t, 4);
    t = at;
    wait_sig(1, 1'b1, 20, at);
    chk("lock_lat_5", at - t, 5);

    // Bypass ratio 1, then ratio 3 with an immediate drain
    @(negedge clk);
    cfg_valid = 1'b1; cfg_ratio = 8'd1;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_sig(0, 1'b0, 40, at);
    wait_sig(0, 1'b1, 20, at);
    chk("bypass_ratio", int'(div_ratio), 1);
    chk("bypass_lock_first", int'(locked), 1);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_ratio = 8'd3;
    n0 = cyc;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_sig(0, 1'b0, 20, at);
    chk("bypass_drain_lat", at - n0, 2);
    chk("ratio3_loaded", int'(div_ratio), 3);
    wait_sig(0, 1'b1, 20, at);
    t = at;
    wait_sig(1, 1'b1, 20, at);
    chk("lock_lat_3", at - t, 3);

    // Accept and enable fall together: capture ratio, end in OFF
    @(negedge clk);
    cfg_valid = 1'b1; cfg_ratio = 8'd9; enable = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_sig(0, 1'b0, 20, at);
    @(negedge clk);
    chk("off_ratio9", int'(div_ratio), 9);
    chk("off_clk_en", int'(clk_en), 0);
    chk("off_busy", int'(busy), 0);
    chk("off_ready", int'(cfg_ready), 1);

    // Drain timeout with the divided clock held low
    enable = 1'b1;
    n0 = cyc;
    wait_sig(0, 1'b1, 20, at);
    chk("restart_lat", at - n0, 5);
    t = at;
    wait_sig(1, 1'b1, 20, at);
    chk("lock_lat_9", at - t, 9);
    @(negedge clk);
    hold_low = 1'b1;
    cfg_valid = 1'b1; cfg_ratio = 8'd6;
    n0 = cyc;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_sig(0, 1'b0, 600, at);
    chk("timeout_lat", at - n0, 513);
    chk("timeout_ratio", int'(div_ratio), 6);
    chk("timeout_gate_busy", int'(busy), 1);
    hold_low = 1'b0;

    // Asynchronous reset in the middle of GATE
    @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_clk_en", int'(clk_en), 0);
    chk("arst_ratio", int'(div_ratio), 8);
    chk("arst_locked", int'(locked), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(cfg_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
